// File: rtl/line_sync_gen.sv
// Line/frame timing generator feeding the pattern control FSM (sync, f_sync, endLine, endFrame).
// Define LINE_SYNC_AUTO_REPEAT_EN to restart line 0 after the last line instead of returning to IDLE.
module line_sync_gen #(
  parameter int unsigned LINE_LEN = 1290,
  parameter int unsigned LINES    = 32,
  parameter int unsigned LINE_GAP = 8,
  parameter int unsigned PIX_W    = 11,
  parameter int unsigned LINE_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_req,
  input  logic              abort,
  output logic              f_sync,
  output logic              sync,
  output logic              endLine,
  output logic              endFrame,
  output logic [LINE_W-1:0] line_idx,
  output logic [PIX_W-1:0]  pix_cnt,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned GAP_LAST = (LINE_GAP > 0) ? LINE_GAP - 1 : 0;
  localparam int unsigned GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ACTIVE,
    BLANK
  } state_t;

  state_t             state_q, state_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               done_q, done_d;

  logic pix_last, line_last, gap_last;

  assign pix_last  = (pix_q == PIX_W'(LINE_LEN - 1));
  assign line_last = (line_q == LINE_W'(LINES - 1));
  assign gap_last  = (gap_q == GAP_W'(GAP_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      pix_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      pix_q   <= pix_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    pix_d   = pix_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        line_d = '0;
        pix_d  = '0;
        gap_d  = '0;
        if (frame_req) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        state_d = ACTIVE;
        pix_d   = '0;
      end
      ACTIVE: begin
        if (pix_last) begin
          pix_d = '0;
          gap_d = '0;
          if (line_last) begin
`ifdef LINE_SYNC_AUTO_REPEAT_EN
            if (LINE_GAP > 0) begin
              state_d = BLANK;
            end else begin
              state_d = SYNC;
              line_d  = '0;
              done_d  = 1'b1;
            end
`else
            state_d = IDLE;
            line_d  = '0;
            done_d  = 1'b1;
`endif
          end else if (LINE_GAP > 0) begin
            state_d = BLANK;
          end else begin
            state_d = SYNC;
            line_d  = line_q + 1'b1;
          end
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      BLANK: begin
        if (gap_last) begin
          state_d = SYNC;
          gap_d   = '0;
          // Blanking after the last line only occurs when frames auto-repeat.
          if (line_last) begin
            line_d = '0;
            done_d = 1'b1;
          end else begin
            line_d = line_q + 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      line_d  = '0;
      pix_d   = '0;
      gap_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    sync       = (state_q == SYNC);
    f_sync     = (state_q == SYNC) && (line_q == '0);
    endLine    = (state_q == ACTIVE) && pix_last;
    endFrame   = ((state_q == SYNC) || (state_q == ACTIVE)) && line_last;
    line_idx   = (state_q == IDLE) ? '0 : line_q;
    pix_cnt    = (state_q == ACTIVE) ? pix_q : '0;
    busy       = (state_q != IDLE);
    frame_done = done_q;
  end

endmodule

// File: doc/line_sync_gen.md
Name: line_sync_gen

Overview:
- Timing generator that sits directly upstream of the pattern control FSM.
- Produces the per-line sync pulse, first-line marker (f_sync), end-of-line pulse (endLine) and last-line level (endFrame) that drive the control FSM's IDLE/START/run/IDLE sequence.
- Counts active pixels per line, blanking cycles between lines, and lines per frame.
- Also reports line index, pixel position and busy/done status to the rest of the pattern datapath.

Parameters:
- LINE_LEN, 1290: active cycles per line (≥2).
- LINES, 32: lines per frame (2..2^LINE_W); matches the 5-bit row counter.
- LINE_GAP, 8: blanking cycles between consecutive lines (0 allowed).
- PIX_W, 11: pixel counter width; 2^PIX_W ≥ LINE_LEN.
- LINE_W, 5: line counter width.

Ports:
- clk  in  1  master clock, 16 ns.
- rst  in  1  asynchronous reset, active-high.
- frame_req  in  1  start one frame; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE.
- f_sync  out  1  high with sync on line 0 only.
- sync  out  1  one-cycle pulse at the start of every line.
- endLine  out  1  one-cycle pulse on the last active cycle of each line.
- endFrame  out  1  level high for the whole of the last line (SYNC, ACTIVE).
- line_idx  out  LINE_W  current line, 0..LINES-1.
- pix_cnt  out  PIX_W  active pixel index, 0..LINE_LEN-1; 0 outside ACTIVE.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse in the first IDLE cycle after a completed frame.

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0, counters 0. Release takes effect on the next clk edge.
- Outputs are decoded from registered state and counters only; no input-to-output combinational path.

States:
- IDLE:
  - All outputs 0 except frame_done.
  - frame_req=1 & abort=0 → SYNC, line_idx=0.
- SYNC: exactly 1 cycle.
  - sync=1.
  - f_sync=(line_idx==0).
  - endFrame=(line_idx==LINES-1).
  - → ACTIVE with pix_cnt=0.
- ACTIVE:
  - pix_cnt increments by 1 per cycle.
  - endLine=1 when pix_cnt==LINE_LEN-1.
  - On that cycle:
    - last line → IDLE, frame_done=1 next cycle.
    - else LINE_GAP>0 → BLANK.
    - else → SYNC with line_idx+1.
- BLANK:
  - gap counter runs LINE_GAP cycles.
  - On the final cycle → SYNC, line_idx+1.
  - sync/endLine/f_sync=0; endFrame=0.

Latency and timing:
- frame_req sampled high at edge N → sync/f_sync high in cycle N+1.
- Frame length = LINES*(1+LINE_LEN) + (LINES-1)*LINE_GAP cycles.
- endLine and endFrame coincide on exactly one cycle per frame (the last pixel). The control FSM exits to IDLE on it.

Boundaries:
- frame_req while busy: ignored, not queued.
- abort in any state: next cycle IDLE, all outputs 0, frame_done not pulsed. abort wins over a simultaneous frame_req.
- Reset mid-frame: immediate IDLE, no frame_done.
- line_idx never exceeds LINES-1. pix_cnt never exceeds LINE_LEN-1. No wrap inside a frame.
- LINE_GAP=0: SYNC immediately follows the endLine cycle.

Optional Feature:
- Macro: LINE_SYNC_AUTO_REPEAT_EN.
- Defined:
  - On completion of the last line, the block goes to SYNC of line 0 after LINE_GAP blanking cycles instead of IDLE.
  - frame_done still pulses for one cycle in that first SYNC cycle.
  - Frames repeat until abort or reset; frame_req is needed only for the first frame.
- Undefined: single-frame behaviour exactly as above.

Test Plan:
- Basic frame (LINE_LEN=4, LINES=2, LINE_GAP=2): frame_req=1 in cycle 0 → cycles 2-5 ACTIVE pix_cnt 0..3, endLine cycle 5, cycles 6-7 blank, cycle 8 sync=1 f_sync=0 endFrame=1, endLine&endFrame cycle 12, frame_done cycle 13, busy high cycles 1-12.
  - cycle 1: sync=1, f_sync=1, line_idx=0.
- Zero gap (LINE_LEN=4, LINES=3, LINE_GAP=0): sync pulses at cycles 1, 6, 11; endFrame high cycles 11-15; frame_done at 16.
- Abort: default params, abort=1 at pix_cnt=500 of line 7 → next cycle all outputs 0, busy=0, no frame_done; frame_req 2 cycles later → clean f_sync on line 0.
- Ignored request plus async reset: frame_req held high throughout a frame → exactly one frame, then a new one starts immediately from IDLE (sync 1 cycle after frame_done cycle). rst=1 asserted mid-cycle → outputs 0 before the next edge.
- Default params full frame: exactly 32 sync pulses, one f_sync, 32 endLine pulses, endFrame high only on line 31. Total busy cycles = 32*1291 + 31*8 = 41560.
- With LINE_SYNC_AUTO_REPEAT_EN (LINE_LEN=4, LINES=2, LINE_GAP=2): after endLine&endFrame at cycle 12, blank cycles 13-14, cycle 15 sync=1 f_sync=1 frame_done=1; abort stops it.
